// File: rtl/pipe_pkg.sv
// Shared types for the pipelined processor's fetch stage: fetch FSM encoding,
// queue entry layout and default datapath widths.
package pipe_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_e;

    // Plain-vector aliases so state registers stay simple logic for older tools
    localparam logic [1:0] ST_IDLE   = FETCH_IDLE;
    localparam logic [1:0] ST_RUN    = FETCH_RUN;
    localparam logic [1:0] ST_HALTED = FETCH_HALTED;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr} pairs between IF and ID, with a
// single-cycle clear that wins over any push or pop in the same cycle.
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_instr,
    input  logic                  pop,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_instr,
    output logic [CNT_W-1:0]      count
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign do_push = push && !clear && !full;
    assign do_pop  = pop && !clear && valid;

    assign head_pc    = mem[rd_ptr].pc;
    assign head_instr = mem[rd_ptr].instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: issues sequential im reads with one-cycle latency,
// buffers results in fetch_queue and squashes everything on redirect or STOP.
module if_prefetch_unit
    import pipe_pkg::*;
#(
    parameter int ADDR_WIDTH               = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH               = DEF_DATA_WIDTH,
    parameter int DEPTH                    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    localparam int CNT_W                   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic [ADDR_WIDTH-1:0] im_addr_o,
    output logic                  im_rd_o,
    input  logic [DATA_WIDTH-1:0] im_r_data_i,
    input  logic                  stall_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  halted_o
);

    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] issued_pc;
    logic                  inflight;
    logic                  running;
    logic                  kill;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        credit_used;

    assign running  = (state == ST_RUN);
    assign halted_o = (state == ST_HALTED);

    // Kill covers both the queue contents and any response landing this cycle
    assign kill = running && (stop_i || redirect_i);

    // Credit counts the in-flight slot but never a same-cycle pop
    assign credit_used = {1'b0, count_o} + {{CNT_W{1'b0}}, inflight};
    assign issue       = running && !redirect_i && !stop_i && (credit_used < DEPTH_L);

    assign im_rd_o   = issue;
    assign im_addr_o = fetch_pc;

    assign push = inflight && !kill;
    assign pop  = valid_o && !stall_i && !kill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state <= ST_RUN;
                ST_RUN:    if (stop_i) state <= ST_HALTED;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // A redirect only retargets the PC; stop freezes it since nothing issues again
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued_pc <= fetch_pc;
                fetch_pc  <= fetch_pc + ADDR_WIDTH'(1);
            end else if (running && !stop_i && redirect_i) begin
                fetch_pc <= redirect_addr_i;
            end
        end
    end

    fetch_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .clear      (kill),
        .push       (push),
        .push_pc    (issued_pc),
        .push_instr (im_r_data_i),
        .pop        (pop),
        .valid      (valid_o),
        .head_pc    (pc_o),
        .head_instr (instr_o),
        .count      (count_o)
    );

endmodule
